// File: rtl/rx_huge_page_ctrl_pkg.sv
// rx_huge_page_ctrl_pkg: shared constants and FSM encoding
// for the RX huge-page controller.
package rx_huge_page_ctrl_pkg;

  localparam int unsigned C_HDR_QW  = 16;
  localparam int unsigned C_PAGE_QW = 1 << 18;

  localparam logic SEL_DATA   = 1'b0;
  localparam logic SEL_NOTIFY = 1'b1;

  localparam int I_IDLE = 0;
  localparam int I_TAIL = 1;
  localparam int I_WAIT = 2;
  localparam int I_NTFY = 3;
  localparam int I_SWCH = 4;
  localparam int I_HOLD = 5;

  typedef enum logic [5:0] {
    S_IDLE     = 6'b000001,
    S_TAIL     = 6'b000010,
    S_WAIT_RDY = 6'b000100,
    S_NOTIFY   = 6'b001000,
    S_SWITCH   = 6'b010000,
    S_HOLD     = 6'b100000
  } hp_state_e;

endpackage

// File: rtl/rx_huge_page_ctrl_slot_regs.sv
// hp_slot_regs: the two host huge-page slots, active-slot
// pointer, arm/clear arbitration and sticky arm_error.
module hp_slot_regs #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_hp1_arm,
  input  logic              i_hp2_arm,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_clr_act,
  output logic              o_flag1,
  output logic              o_flag2,
  output logic              o_flag_act,
  output logic [ADDR_W-1:0] o_base_act,
  output logic              o_arm_error
);

  logic [ADDR_W-1:0] r_base1;
  logic [ADDR_W-1:0] r_base2;
  logic              r_flag1;
  logic              r_flag2;
  logic              r_act2;
  logic              r_arm_error;
  logic [ADDR_W-1:0] w_addr;
  logic              w_clr1;
  logic              w_clr2;
  logic              w_bad1;
  logic              w_bad2;
  logic              w_set1;
  logic              w_set2;

  assign w_addr = i_addr & ~ADDR_W'(7);
  assign w_clr1 = i_clr_act & ~r_act2;
  assign w_clr2 = i_clr_act & r_act2;
  // a slot being closed this cycle may be re-armed
  assign w_bad1 = i_hp1_arm & ~r_act2 & r_flag1 & ~w_clr1;
  assign w_bad2 = i_hp2_arm & r_act2 & r_flag2 & ~w_clr2;
  assign w_set1 = i_hp1_arm & ~w_bad1;
  assign w_set2 = i_hp2_arm & ~w_bad2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_base1     <= '0;
      r_base2     <= '0;
      r_flag1     <= 1'b0;
      r_flag2     <= 1'b0;
      r_act2      <= 1'b0;
      r_arm_error <= 1'b0;
    end else begin
      if (w_set1) begin
        r_base1 <= w_addr;
        r_flag1 <= 1'b1;
      end else if (w_clr1) begin
        r_flag1 <= 1'b0;
      end
      if (w_set2) begin
        r_base2 <= w_addr;
        r_flag2 <= 1'b1;
      end else if (w_clr2) begin
        r_flag2 <= 1'b0;
      end
      if (i_clr_act)
        r_act2 <= ~r_act2;
      if (w_bad1 | w_bad2)
        r_arm_error <= 1'b1;
    end
  end

  assign o_flag1     = r_flag1;
  assign o_flag2     = r_flag2;
  assign o_flag_act  = r_act2 ? r_flag2 : r_flag1;
  assign o_base_act  = r_act2 ? r_base2 : r_base1;
  assign o_arm_error = r_arm_error;

endmodule

// File: rtl/rx_huge_page_ctrl.sv
// rx_huge_page_ctrl: RX huge-page owner and page-close sequencer.
// Optional hp_switch_cnt/hp_stall_cnt outputs under `HP_STATS_EN.
module rx_huge_page_ctrl
  import rx_huge_page_ctrl_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int QW_W   = 19,
  parameter int HDR_QW = C_HDR_QW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hp1_arm,
  input  logic              hp2_arm,
  input  logic [ADDR_W-1:0] hp_addr_in,
  output logic              huge_page_status_1,
  output logic              huge_page_status_2,
  input  logic              change_huge_page,
  input  logic              send_last_tlp,
  input  logic [4:0]        qwords_to_send,
  output logic              change_huge_page_ack,
  input  logic              data_tlp_sent,
  input  logic [4:0]        data_tlp_qw,
  output logic [ADDR_W-1:0] cur_wr_addr,
  output logic              tx_req,
  output logic              tx_is_notify,
  output logic [ADDR_W-1:0] tx_addr,
  output logic [QW_W-1:0]   tx_qw,
  input  logic              tx_ack,
  output logic              arm_error
`ifdef HP_STATS_EN
  ,
  output logic [31:0]       hp_switch_cnt,
  output logic [31:0]       hp_stall_cnt
`endif
);

  hp_state_e         r_state;
  hp_state_e         w_nxt;
  logic [QW_W-1:0]   r_offset;
  logic [QW_W-1:0]   w_off_nxt;
  logic [QW_W:0]     w_sum;
  logic [4:0]        r_tail;
  logic [4:0]        w_tail;
  logic [4:0]        w_data_add;
  logic [4:0]        w_tail_add;
  logic              r_tx_req;
  logic              w_tx_req;
  logic              r_is_notify;
  logic              w_is_notify;
  logic              r_ack;
  logic              w_ack;
  logic              w_clr;
  logic [ADDR_W-1:0] r_tx_addr;
  logic [ADDR_W-1:0] w_tx_addr;
  logic [QW_W-1:0]   r_tx_qw;
  logic [QW_W-1:0]   w_tx_qw;
  logic [ADDR_W-1:0] r_cur;
  logic [ADDR_W-1:0] w_base_act;
  logic [ADDR_W-1:0] w_off_bytes;
  logic              w_flag_act;

  hp_slot_regs #(.ADDR_W(ADDR_W)) u_slots (
    .clk        (clk),
    .reset      (reset),
    .i_hp1_arm  (hp1_arm),
    .i_hp2_arm  (hp2_arm),
    .i_addr     (hp_addr_in),
    .i_clr_act  (w_clr),
    .o_flag1    (huge_page_status_1),
    .o_flag2    (huge_page_status_2),
    .o_flag_act (w_flag_act),
    .o_base_act (w_base_act),
    .o_arm_error(arm_error)
  );

  assign w_off_bytes = ADDR_W'({r_offset, 3'b000});
  assign w_data_add  = data_tlp_sent ? data_tlp_qw : 5'd0;
  assign w_tail_add  = (r_state == S_TAIL && tx_ack) ? r_tail : 5'd0;
  assign w_sum = {1'b0, r_offset} + (QW_W+1)'(w_data_add)
               + (QW_W+1)'(w_tail_add);
  assign w_off_nxt = (w_sum > (QW_W+1)'(C_PAGE_QW)) ?
                     QW_W'(C_PAGE_QW) : w_sum[QW_W-1:0];

  always_comb begin
    w_nxt       = r_state;
    w_tail      = r_tail;
    w_tx_req    = r_tx_req;
    w_is_notify = r_is_notify;
    w_tx_addr   = r_tx_addr;
    w_tx_qw     = r_tx_qw;
    w_ack       = 1'b0;
    w_clr       = 1'b0;
    unique case (1'b1)
      r_state[I_IDLE]: begin
        if (send_last_tlp) begin
          w_nxt       = S_TAIL;
          w_tail      = qwords_to_send;
          w_tx_req    = 1'b1;
          w_is_notify = SEL_DATA;
          w_tx_addr   = w_base_act + w_off_bytes;
          w_tx_qw     = QW_W'(qwords_to_send);
        end else if (change_huge_page) begin
          w_nxt = S_WAIT_RDY;
        end
      end
      r_state[I_TAIL]: begin
        if (tx_ack) begin
          w_nxt    = S_WAIT_RDY;
          w_tx_req = 1'b0;
        end
      end
      r_state[I_WAIT]: begin
        if (w_flag_act) begin
          w_nxt       = S_NOTIFY;
          w_tx_req    = 1'b1;
          w_is_notify = SEL_NOTIFY;
          w_tx_addr   = w_base_act;
          w_tx_qw     = r_offset - QW_W'(HDR_QW);
        end
      end
      r_state[I_NTFY]: begin
        if (tx_ack) begin
          w_nxt    = S_SWITCH;
          w_tx_req = 1'b0;
          w_ack    = 1'b1;
        end
      end
      r_state[I_SWCH]: begin
        w_nxt = S_HOLD;
        w_clr = 1'b1;
      end
      r_state[I_HOLD]: begin
        if (!change_huge_page && !send_last_tlp)
          w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_offset    <= QW_W'(HDR_QW);
      r_tail      <= '0;
      r_tx_req    <= 1'b0;
      r_is_notify <= SEL_DATA;
      r_tx_addr   <= '0;
      r_tx_qw     <= '0;
      r_ack       <= 1'b0;
      r_cur       <= ADDR_W'(HDR_QW * 8);
    end else begin
      r_state     <= w_nxt;
      r_offset    <= (r_state == S_SWITCH) ? QW_W'(HDR_QW) : w_off_nxt;
      r_tail      <= w_tail;
      r_tx_req    <= w_tx_req;
      r_is_notify <= w_is_notify;
      r_tx_addr   <= w_tx_addr;
      r_tx_qw     <= w_tx_qw;
      r_ack       <= w_ack;
      // registered copy trails base/offset updates by one cycle
      r_cur       <= w_base_act + w_off_bytes;
    end
  end

  assign change_huge_page_ack = r_ack;
  assign tx_req               = r_tx_req;
  assign tx_is_notify         = r_is_notify;
  assign tx_addr              = r_tx_addr;
  assign tx_qw                = r_tx_qw;
  assign cur_wr_addr          = r_cur;

`ifdef HP_STATS_EN
  logic [31:0] r_sw_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sw_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (r_state == S_SWITCH && r_sw_cnt != '1)
        r_sw_cnt <= r_sw_cnt + 32'd1;
      if (r_state == S_WAIT_RDY && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign hp_switch_cnt = r_sw_cnt;
  assign hp_stall_cnt  = r_stall_cnt;
`endif

endmodule

// File: tb/tb_rx_huge_page_ctrl.sv
// tb_rx_huge_page_ctrl: self-checking bench for rx_huge_page_ctrl.
// Vector table, directed close sequences, random ops against a slot/offset model.
module tb_rx_huge_page_ctrl;

  localparam int AW   = 64;
  localparam int QW   = 19;
  localparam int HDR  = 16;
  localparam int PAGE = 1 << 18;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          hp1_arm = 1'b0;
  logic          hp2_arm = 1'b0;
  logic [AW-1:0] hp_addr_in = '0;
  logic          huge_page_status_1;
  logic          huge_page_status_2;
  logic          change_huge_page = 1'b0;
  logic          send_last_tlp = 1'b0;
  logic [4:0]    qwords_to_send = 5'd1;
  logic          change_huge_page_ack;
  logic          data_tlp_sent = 1'b0;
  logic [4:0]    data_tlp_qw = 5'd0;
  logic [AW-1:0] cur_wr_addr;
  logic          tx_req;
  logic          tx_is_notify;
  logic [AW-1:0] tx_addr;
  logic [QW-1:0] tx_qw;
  logic          tx_ack = 1'b0;
  logic          arm_error;
`ifdef HP_STATS_EN
  logic [31:0]   hp_switch_cnt;
  logic [31:0]   hp_stall_cnt;
`endif

  rx_huge_page_ctrl dut (
    .clk                 (clk),
    .reset               (reset),
    .hp1_arm             (hp1_arm),
    .hp2_arm             (hp2_arm),
    .hp_addr_in          (hp_addr_in),
    .huge_page_status_1  (huge_page_status_1),
    .huge_page_status_2  (huge_page_status_2),
    .change_huge_page    (change_huge_page),
    .send_last_tlp       (send_last_tlp),
    .qwords_to_send      (qwords_to_send),
    .change_huge_page_ack(change_huge_page_ack),
    .data_tlp_sent       (data_tlp_sent),
    .data_tlp_qw         (data_tlp_qw),
    .cur_wr_addr         (cur_wr_addr),
    .tx_req              (tx_req),
    .tx_is_notify        (tx_is_notify),
    .tx_addr             (tx_addr),
    .tx_qw               (tx_qw),
    .tx_ack              (tx_ack),
    .arm_error           (arm_error)
`ifdef HP_STATS_EN
    ,
    .hp_switch_cnt       (hp_switch_cnt),
    .hp_stall_cnt        (hp_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [63:0] m_base [2];
  bit          m_flag [2];
  int          m_act;
  int          m_off;
  bit          m_err;

  int n_chk = 0;
  int n_pass = 0;
  int ack_cnt = 0;

  always @(posedge clk)
    if (!reset && change_huge_page_ack) ack_cnt <= ack_cnt + 1;

  typedef struct {
    bit          a1;
    bit          a2;
    logic [63:0] addr;
    bit          dv;
    int          dq;
    bit          e_s1;
    bit          e_s2;
    bit          e_err;
    logic [63:0] e_cur;
  } vec_t;

  vec_t vt [5];

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input longint v);
    return (v > PAGE) ? PAGE : int'(v);
  endfunction

  function automatic logic [63:0] m_cur();
    return m_base[m_act] + 64'(m_off) * 64'd8;
  endfunction

  task automatic m_reset();
    m_base[0] = '0; m_base[1] = '0;
    m_flag[0] = 0;  m_flag[1] = 0;
    m_act = 0; m_off = HDR; m_err = 0;
  endtask

  task automatic m_arm(input int s, input logic [63:0] a);
    if (s == m_act && m_flag[s]) m_err = 1;
    else begin
      m_base[s] = a & ~64'h7;
      m_flag[s] = 1;
    end
  endtask

  task automatic drive(input bit a1, input bit a2, input logic [63:0] a,
                       input bit dv, input int dq);
    hp1_arm = a1; hp2_arm = a2; hp_addr_in = a;
    data_tlp_sent = dv; data_tlp_qw = 5'(dq);
    tick();
    hp1_arm = 0; hp2_arm = 0; data_tlp_sent = 0;
    if (a1) m_arm(0, a);
    if (a2) m_arm(1, a);
    if (dv) m_off = sat(longint'(m_off) + dq);
  endtask

  task automatic check_state(input string tag);
    @(posedge clk);
    @(negedge clk);
    check({tag, ".st1"}, huge_page_status_1, m_flag[0]);
    check({tag, ".st2"}, huge_page_status_2, m_flag[1]);
    check({tag, ".cur"}, cur_wr_addr, m_cur());
    check({tag, ".err"}, arm_error, m_err);
    check({tag, ".idle_req"}, tx_req, 0);
  endtask

  task automatic wait_req(input int max, output int n);
    n = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (tx_req) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic ack_tx(input string tag);
    int d;
    d = $urandom_range(0, 3);
    repeat (d) @(negedge clk);
    check({tag, ".req_held"}, tx_req, 1);
    tx_ack = 1;
    tick();
    tx_ack = 0;
  endtask

  task automatic close_page(input string tag, input bit tail, input int tq,
                            input bit stall, input logic [63:0] st_addr,
                            input bit arm_sw, input logic [63:0] sw_addr,
                            input int hold,
                            output logic [63:0] t_addr,
                            output logic [63:0] n_addr, output int n_qw);
    int a0, n, extra;
    a0 = ack_cnt;
    t_addr = '0; n_addr = '0; n_qw = -1;
    if (tail) begin
      send_last_tlp = 1;
      qwords_to_send = 5'(tq);
    end else change_huge_page = 1;
    if (tail) begin
      wait_req(20, n);
      check({tag, ".tail_seen"}, n >= 0, 1);
      t_addr = tx_addr;
      check({tag, ".tail_kind"}, tx_is_notify, 0);
      check({tag, ".tail_addr"}, tx_addr, m_cur());
      check({tag, ".tail_qw"}, tx_qw, tq);
      ack_tx(tag);
      m_off = sat(longint'(m_off) + tq);
    end
    if (stall) begin
      extra = 0;
      repeat (10) begin
        @(negedge clk);
        if (tx_req) extra++;
      end
      check({tag, ".stall_noreq"}, extra, 0);
      check({tag, ".stall_noack"}, ack_cnt - a0, 0);
      drive(m_act == 0, m_act == 1, st_addr, 0, 0);
      wait_req(2, n);
    end else wait_req(20, n);
    check({tag, ".notify_seen"}, n >= 0, 1);
    n_addr = tx_addr;
    n_qw = int'(tx_qw);
    check({tag, ".ntf_kind"}, tx_is_notify, 1);
    check({tag, ".ntf_addr"}, tx_addr, m_base[m_act]);
    check({tag, ".ntf_qw"}, tx_qw, m_off - HDR);
    ack_tx(tag);
    m_flag[m_act] = 0;
    m_act ^= 1;
    m_off = HDR;
    if (arm_sw) drive(m_act == 1, m_act == 0, sw_addr, 0, 0);
    extra = 0;
    repeat (hold) begin
      @(negedge clk);
      if (tx_req) extra++;
    end
    send_last_tlp = 0;
    change_huge_page = 0;
    repeat (3) @(negedge clk);
    check({tag, ".one_ack"}, ack_cnt - a0, 1);
    check({tag, ".no_renotify"}, extra, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ta, na;
    int nq, n, op, s;
    logic [63:0] ra;

    vt[0] = '{1, 0, 64'h1000_0000, 0, 0,  1, 0, 0, 64'h1000_0080};
    vt[1] = '{0, 0, 64'h0,         1, 16, 1, 0, 0, 64'h1000_0100};
    vt[2] = '{0, 0, 64'h0,         1, 16, 1, 0, 0, 64'h1000_0180};
    vt[3] = '{0, 0, 64'h0,         1, 16, 1, 0, 0, 64'h1000_0200};
    vt[4] = '{1, 0, 64'h3000_0000, 0, 0,  1, 0, 1, 64'h1000_0200};

    m_reset();
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("rst.st1", huge_page_status_1, 0);
    check("rst.st2", huge_page_status_2, 0);
    check("rst.req", tx_req, 0);
    check("rst.ack", change_huge_page_ack, 0);
    check("rst.err", arm_error, 0);
    check("rst.cur", cur_wr_addr, 64'h80);

    for (int i = 0; i < 5; i++) begin
      drive(vt[i].a1, vt[i].a2, vt[i].addr, vt[i].dv, vt[i].dq);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d.st1", i), huge_page_status_1, vt[i].e_s1);
      check($sformatf("vec%0d.st2", i), huge_page_status_2, vt[i].e_s2);
      check($sformatf("vec%0d.err", i), arm_error, vt[i].e_err);
      check($sformatf("vec%0d.cur", i), cur_wr_addr, vt[i].e_cur);
    end

    close_page("p1", 0, 0, 0, 0, 0, 0, 10, ta, na, nq);
    check("p1.addr_k", na, 64'h1000_0000);
    check("p1.qw_k", nq, 48);
    check_state("p1.after");
    check("p1.st1_k", huge_page_status_1, 0);
    check("p1.cur_k", cur_wr_addr, 64'h80);

    close_page("stall", 0, 0, 1, 64'h2000_0000, 0, 0, 10, ta, na, nq);
    check("stall.addr_k", na, 64'h2000_0000);
    check("stall.qw_k", nq, 0);
    check_state("stall.after");

    drive(1, 0, 64'h4000_0000, 0, 0);
    drive(0, 0, 64'h0, 1, 16);
    close_page("tail", 1, 5, 0, 0, 0, 0, 4, ta, na, nq);
    check("tail.taddr_k", ta, 64'h4000_0100);
    check("tail.qw_k", nq, 21);
    check_state("tail.after");

    drive(0, 1, 64'h5000_0000, 0, 0);
    close_page("armclr", 0, 0, 0, 0, 1, 64'h6000_0000, 3, ta, na, nq);
    check_state("armclr.after");
    check("armclr.st2_k", huge_page_status_2, 1);

    drive(1, 1, 64'h7000_0008, 0, 0);
    check_state("both");
    check("both.cur_k", cur_wr_addr, 64'h7000_0088);

    data_tlp_sent = 1;
    data_tlp_qw = 5'd16;
    repeat (16400) @(posedge clk);
    #1 data_tlp_sent = 0;
    m_off = sat(longint'(m_off) + 16400 * 16);
    check_state("sat");
    check("sat.cur_k", cur_wr_addr, 64'h7020_0008);
    close_page("satclose", 0, 0, 0, 0, 0, 0, 2, ta, na, nq);
    check("sat.qw_k", nq, PAGE - HDR);

    send_last_tlp = 1;
    qwords_to_send = 5'd3;
    wait_req(20, n);
    check("rsttail.req", tx_req, 1);
    reset = 1;
    tick();
    check("rsttail.req0", tx_req, 0);
    check("rsttail.st1", huge_page_status_1, 0);
    check("rsttail.st2", huge_page_status_2, 0);
    check("rsttail.ack", change_huge_page_ack, 0);
    check("rsttail.cur", cur_wr_addr, 64'h80);
    send_last_tlp = 0;
    tick();
    reset = 0;
    m_reset();
    check_state("rsttail.after");

    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 9);
      if (op < 3) begin
        s = $urandom_range(0, 1);
        ra = {$urandom, $urandom};
        drive(s == 0, s == 1, ra, 0, 0);
      end else if (op < 7) begin
        drive(0, 0, 64'h0, 1, $urandom_range(1, 16));
      end else if (op < 8) begin
        tx_ack = 1;
        tick();
        tx_ack = 0;
      end else begin
        if (!m_flag[m_act]) begin
          ra = {$urandom, $urandom};
          drive(m_act == 0, m_act == 1, ra, 0, 0);
        end
        close_page("rnd", 1'($urandom_range(0, 1)), $urandom_range(1, 16),
                   0, 0, 0, 0, $urandom_range(1, 10), ta, na, nq);
      end
      check_state("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rx_huge_page_ctrl.md
Name: rx_huge_page_ctrl

Overview:
Owns the two host huge-page slots used by the RX path and sequences every page close.
- Holds the host-armed base addresses and ready flags for slot 1 and slot 2.
- Serves change_huge_page / send_last_tlp requests from rx_tlp_trigger.
- Issues the optional last data TLP and the page-close notify TLP through the TX engine, then ping-pongs the active slot and acks.

Parameters:
ADDR_W, 64, host address width
QW_W, 19, qword counter width (2 MB page = 2^18 qwords)
HDR_QW, 16, qwords reserved at page start for the header; data offset restarts here

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high
hp1_arm  in  1  pulse: host arms slot 1 with hp_addr_in
hp2_arm  in  1  pulse: host arms slot 2 with hp_addr_in
hp_addr_in  in  ADDR_W  base address written by host (bits[2:0] ignored)
huge_page_status_1  out  1  slot 1 armed
huge_page_status_2  out  1  slot 2 armed
change_huge_page  in  1  level request: close page, no tail data
send_last_tlp  in  1  level request: send tail TLP, then close page
qwords_to_send  in  5  tail size, 1..16
change_huge_page_ack  out  1  one-cycle ack for either request
data_tlp_sent  in  1  pulse: a data TLP of data_tlp_qw was committed
data_tlp_qw  in  5  qwords in that TLP
cur_wr_addr  out  ADDR_W  base(active) + 8*qword_offset
tx_req  out  1  level request to TX engine
tx_is_notify  out  1  1=notify TLP, 0=tail data TLP
tx_addr  out  ADDR_W  target address for tx_req
tx_qw  out  QW_W  tail qwords, or page qword count for notify
tx_ack  in  1  TX engine accepted request
arm_error  out  1  sticky: host armed the active slot

Behaviour:
- Reset: slot flags 0, active slot 1, offset=HDR_QW, tx_req=0, ack=0, arm_error=0, FSM IDLE; base addresses 0.
- Arm: slot flag set, base latched. Arming the active slot while its flag=1 → ignored, arm_error set. Both arms in one cycle → both applied. Arm in the same cycle as the clear of that slot → arm wins.
- data_tlp_sent: offset += data_tlp_qw, same cycle; offset saturates at 2^18 in QW_W bits.
- FSM (one-hot):
  - IDLE: send_last_tlp has priority over change_huge_page. send_last_tlp → TAIL (latch qwords_to_send); change_huge_page → WAIT_RDY.
  - TAIL: tx_req=1, tx_is_notify=0, tx_addr=cur_wr_addr, tx_qw=tail. On tx_ack: drop tx_req, offset += tail, go WAIT_RDY.
  - WAIT_RDY: wait until the active slot flag=1 (stalls indefinitely if the host has not armed it), then go NOTIFY.
  - NOTIFY: tx_req=1, tx_is_notify=1, tx_addr=base(active), tx_qw=offset-HDR_QW (data qwords only). On tx_ack → SWITCH.
  - SWITCH: clear active flag, toggle active slot, offset=HDR_QW, ack=1 for one cycle → HOLD.
  - HOLD: ack=0. Return to IDLE only after both requests are deasserted, so a level request is never double-served.
- tx_req never drops without tx_ack.
- A tx_ack while tx_req=0 is ignored.
- Reset mid-sequence returns to the reset state immediately; no partial ack.
- All outputs are registered.

Optional Feature:
HP_STATS_EN. When defined, adds outputs:
- hp_switch_cnt[31:0]: increments in SWITCH.
- hp_stall_cnt[31:0]: cycles spent in WAIT_RDY.
Both saturate, and both clear on reset.
When undefined, these ports and their counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package: FSM state encodings, HDR_QW, page-size constant (2^18 qwords), and the notify/data selector encoding.
- One natural sub-module: hp_slot_regs. It holds the two base/flag pairs, the arm/clear logic and arm_error, and outputs the active base plus flags.

Test Plan:
- Arm slot1=0x1000_0000, send 3 data TLPs of 16 qw, pulse change_huge_page → notify at 0x1000_0000 with tx_qw=48; ack after tx_ack; status_1=0; cur_wr_addr = base2 + 0x80.
- send_last_tlp with qwords_to_send=5 after 16 qw sent → tail TLP at base+8*(16+16), tx_qw=5; then notify tx_qw=21; single ack.
- change_huge_page with slot 2 next and unarmed after the first switch → FSM stays in WAIT_RDY, no tx_req; arm slot2 → notify within 2 cycles.
- Request held high for 10 cycles after ack → exactly one ack, no second notify.
- Arm the active armed slot → arm_error=1, base unchanged. Arm slot 2 in the same cycle as its clear → status_2=1.
- Assert reset while TAIL has tx_req=1 → next cycle tx_req=0, flags=0, offset=16.
